mxalu11u_exec: RTL and testbench
================================

MXALU11U_EXEC -- requirements
Module: mxalu11u_exec

Interface
REQ-001 Parameter: none; all widths fixed (8-bit data, 4-bit opcode).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  upstream request present.
REQ-005 req_ready  out  1  request accepted on a cycle where req_valid & req_ready.
REQ-006 req_opcode  in  4  ALU opcode, passed unchanged to the ALU.
REQ-007 req_a  in  8  operand A when req_a_acc=0.
REQ-008 req_a_acc  in  1  1: operand A = accumulator.
REQ-009 req_b  in  8  operand B.
REQ-010 req_wr_acc  in  1  1: write result into accumulator on capture.
REQ-011 alu_opcode / alu_a / alu_b  out  4/8/8  registered drive to ALU opcode/a/b.
REQ-012 alu_cs_n  out  1  ALU select, active-low.
REQ-013 alu_f  in  8; alu_cn8_n, alu_a_b  in  1 each  ALU result, active-low carry-out, A=B.
REQ-014 res_valid  out  1  result available; res_ready  in  1  downstream accepts.
REQ-015 res_f  out  8  captured result; res_flags  out  4  {C,Z,N,E}, bit3..0.
REQ-016 acc  out  8  accumulator; op_cnt  out  8  completed-operation count.

Function
REQ-017 FSM states IDLE, ISSUE, DONE; exactly one active.
REQ-018 req_ready SHALL = (state==IDLE) | (state==DONE & res_ready); combinational.
REQ-019 On accept: register alu_opcode=req_opcode, alu_a=(req_a_acc ? acc : req_a), alu_b=req_b, latch req_wr_acc; next state ISSUE.
REQ-020 alu_cs_n SHALL be 0 only while state==ISSUE, 1 otherwise.
REQ-021 ISSUE lasts exactly one cycle; at its end capture res_f=alu_f, C=~alu_cn8_n, Z=(alu_f==0), N=alu_f[7], E=alu_a_b; next state DONE.
REQ-022 On capture with latched wr_acc=1: acc<=alu_f same edge; else acc unchanged.
REQ-023 On capture op_cnt increments by 1, wrapping 0xFF->0x00.
REQ-024 res_valid SHALL = (state==DONE); res_f/res_flags stable while res_valid & !res_ready.
REQ-025 DONE & res_ready & !req_valid -> IDLE; DONE & res_ready & req_valid -> ISSUE (back-to-back, REQ-019 applies).
REQ-026 DONE & !res_ready: hold; req_ready=0; no new accept.
REQ-027 Latency: accept at edge T -> cs_n low cycle T..T+1 -> res_valid high after edge T+1; sustained throughput one op per 2 cycles.
REQ-028 Accumulator-sourced A in back-to-back accept SHALL use acc value after the capture of the previous op (acc updated before DONE, so already current).
REQ-029 alu_opcode/alu_a/alu_b hold last issued values outside ISSUE.
REQ-030 req_* inputs ignored when no accept occurs.

Reset
REQ-031 rst=1 at edge: state=IDLE, alu_cs_n=1, alu_opcode=0, alu_a=0, alu_b=0, res_f=0, res_flags=0, acc=0, op_cnt=0, res_valid=0.
REQ-032 rst mid-ISSUE or mid-DONE: operation discarded, no acc/op_cnt update, IDLE next cycle; rst overrides simultaneous accept.
REQ-033 First accept possible on first edge after rst deasserts.

Verification (bench stubs ALU: alu_f=a+b, alu_cn8_n=~carry, alu_a_b=(a==b))
REQ-034 Reset: hold rst 2 cycles -> all REQ-031 values; req_ready=1, alu_cs_n=1.
REQ-035 Single op: a=0x12, b=0x34, wr_acc=1, res_ready=1 -> cs_n low 1 cycle, res_f=0x46, flags=0000, acc=0x46, op_cnt=1, res_valid 1 cycle.
REQ-036 Carry/zero: a=0xFF, b=0x01 -> res_f=0x00, flags C=1,Z=1,N=0,E=0 (0b1100).
REQ-037 Accumulator chain: acc=0x46, three back-to-back req_a_acc=1, b=0x10, wr_acc=1 -> results 0x56, 0x66, 0x76; res_valid every 2nd cycle; op_cnt=4.
REQ-038 Backpressure: res_ready=0 for 5 cycles in DONE -> res_f/flags stable, req_ready=0, cs_n=1; release -> one transfer, no duplicate.
REQ-039 Reset in ISSUE with wr_acc=1 -> acc, op_cnt unchanged from pre-op values, IDLE next cycle; 256 ops -> op_cnt wraps to 0x00.

Source files
------------

// File: rtl/mxalu11u_exec.sv
// Request/issue/result sequencer driving an external 8-bit ALU, with an
// accumulator that can source operand A and optionally capture the result.
module mxalu11u_exec (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_opcode,
  input  logic [7:0] req_a,
  input  logic       req_a_acc,
  input  logic [7:0] req_b,
  input  logic       req_wr_acc,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cs_n,
  input  logic [7:0] alu_f,
  input  logic       alu_cn8_n,
  input  logic       alu_a_b,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_f,
  output logic [3:0] res_flags,
  output logic [7:0] acc,
  output logic [7:0] op_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] r_state;
  logic [3:0] r_alu_opcode;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic       r_wr_acc;
  logic [7:0] r_res_f;
  logic [3:0] r_res_flags;
  logic [7:0] r_acc;
  logic [7:0] r_op_cnt;

  logic       w_accept;
  logic [3:0] w_flags;

  assign req_ready = (r_state == IDLE) | ((r_state == DONE) & res_ready);
  assign w_accept  = req_valid & req_ready;

  // Flags packed as {C, Z, N, E}; carry-out from the ALU is active-low.
  assign w_flags = {~alu_cn8_n, (alu_f == 8'h00), alu_f[7], alu_a_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_alu_opcode <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_wr_acc     <= 1'b0;
      r_res_f      <= '0;
      r_res_flags  <= '0;
      r_acc        <= '0;
      r_op_cnt     <= '0;
    end else begin
      // Accept is possible from IDLE or from DONE while the result is taken;
      // the accumulator is already updated by then, so back-to-back reads are current.
      if (w_accept) begin
        r_alu_opcode <= req_opcode;
        r_alu_a      <= req_a_acc ? r_acc : req_a;
        r_alu_b      <= req_b;
        r_wr_acc     <= req_wr_acc;
      end

      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= ISSUE;
        end
        ISSUE: begin
          r_res_f     <= alu_f;
          r_res_flags <= w_flags;
          r_op_cnt    <= r_op_cnt + 8'd1;
          if (r_wr_acc) r_acc <= alu_f;
          r_state     <= DONE;
        end
        DONE: begin
          if (res_ready) r_state <= req_valid ? ISSUE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_cs_n   = (r_state != ISSUE);
  assign res_valid  = (r_state == DONE);
  assign res_f      = r_res_f;
  assign res_flags  = r_res_flags;
  assign acc        = r_acc;
  assign op_cnt     = r_op_cnt;

endmodule

// File: tb/tb_mxalu11u_exec.sv
// Directed bench for mxalu11u_exec with an adder standing in for the ALU.
module tb_mxalu11u_exec;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_opcode;
  logic [7:0] req_a;
  logic       req_a_acc;
  logic [7:0] req_b;
  logic       req_wr_acc;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_cs_n;
  logic [7:0] alu_f;
  logic       alu_cn8_n;
  logic       alu_a_b;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_f;
  logic [3:0] res_flags;
  logic [7:0] acc;
  logic [7:0] op_cnt;

  logic [8:0] w_sum;
  int unsigned errors;
  int unsigned checks;

  mxalu11u_exec dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_a_acc  (req_a_acc),
    .req_b      (req_b),
    .req_wr_acc (req_wr_acc),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cs_n   (alu_cs_n),
    .alu_f      (alu_f),
    .alu_cn8_n  (alu_cn8_n),
    .alu_a_b    (alu_a_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_f      (res_f),
    .res_flags  (res_flags),
    .acc        (acc),
    .op_cnt     (op_cnt)
  );

  assign w_sum     = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_f     = w_sum[7:0];
  assign alu_cn8_n = ~w_sum[8];
  assign alu_a_b   = (alu_a == alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic aacc,
                       input logic [7:0] b, input logic wr);
    req_valid  = v;
    req_a      = a;
    req_a_acc  = aacc;
    req_b      = b;
    req_wr_acc = wr;
  endtask

  logic [7:0] chain_exp [3];

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    res_ready  = 1'b1;
    req_opcode = 4'h0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 16'(req_ready), 16'h1);
    check("rst_cs_n", 16'(alu_cs_n), 16'h1);
    check("rst_alu_op", 16'(alu_opcode), 16'h0);
    check("rst_alu_a", 16'(alu_a), 16'h0);
    check("rst_alu_b", 16'(alu_b), 16'h0);
    check("rst_res_f", 16'(res_f), 16'h0);
    check("rst_flags", 16'(res_flags), 16'h0);
    check("rst_acc", 16'(acc), 16'h0);
    check("rst_op_cnt", 16'(op_cnt), 16'h0);
    check("rst_res_valid", 16'(res_valid), 16'h0);
    rst = 1'b0;

    // Single op 0x12 + 0x34 into the accumulator
    req_opcode = 4'h3;
    drive(1'b1, 8'h12, 1'b0, 8'h34, 1'b1);
    tick();
    check("op1_cs_low", 16'(alu_cs_n), 16'h0);
    check("op1_busy", 16'(req_ready), 16'h0);
    check("op1_valid_early", 16'(res_valid), 16'h0);
    check("op1_alu_op", 16'(alu_opcode), 16'h3);
    check("op1_alu_a", 16'(alu_a), 16'h12);
    check("op1_alu_b", 16'(alu_b), 16'h34);
    drive(1'b0, 8'hAA, 1'b0, 8'hBB, 1'b0);
    tick();
    check("op1_cs_high", 16'(alu_cs_n), 16'h1);
    check("op1_valid", 16'(res_valid), 16'h1);
    check("op1_res_f", 16'(res_f), 16'h46);
    check("op1_flags", 16'(res_flags), 16'h0);
    check("op1_acc", 16'(acc), 16'h46);
    check("op1_cnt", 16'(op_cnt), 16'h1);
    tick();
    check("op1_valid_drop", 16'(res_valid), 16'h0);
    check("op1_hold_a", 16'(alu_a), 16'h12);

    // Carry and zero, accumulator not written
    drive(1'b1, 8'hFF, 1'b0, 8'h01, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    check("cz_res_f", 16'(res_f), 16'h00);
    check("cz_flags", 16'(res_flags), 16'hC);
    check("cz_acc", 16'(acc), 16'h46);
    check("cz_cnt", 16'(op_cnt), 16'h2);
    tick();

    // Equal operands: carry, zero and equal together
    drive(1'b1, 8'h80, 1'b0, 8'h80, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    check("eq_flags", 16'(res_flags), 16'hD);
    tick();

    // Three back-to-back accumulator-sourced adds of 0x10
    chain_exp[0] = 8'h56;
    chain_exp[1] = 8'h66;
    chain_exp[2] = 8'h76;
    drive(1'b1, 8'hEE, 1'b1, 8'h10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("chain_cs_low", 16'(alu_cs_n), 16'h0);
      check("chain_alu_a", 16'(alu_a), (i == 0) ? 16'h46 : 16'(chain_exp[i-1]));
      if (i == 2) req_valid = 1'b0;
      tick();
      check("chain_valid", 16'(res_valid), 16'h1);
      check("chain_res_f", 16'(res_f), 16'(chain_exp[i]));
    end
    check("chain_acc", 16'(acc), 16'h76);
    check("chain_cnt", 16'(op_cnt), 16'h6);
    tick();
    check("chain_idle", 16'(res_valid), 16'h0);

    // Backpressure in DONE; a competing request must not be taken
    res_ready = 1'b0;
    drive(1'b1, 8'h40, 1'b0, 8'h50, 1'b0);
    tick();
    drive(1'b1, 8'h01, 1'b0, 8'h01, 1'b1);
    tick();
    check("bp_res_f", 16'(res_f), 16'h90);
    check("bp_flags", 16'(res_flags), 16'h2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 16'(res_valid), 16'h1);
      check("bp_hold_res_f", 16'(res_f), 16'h90);
      check("bp_hold_flags", 16'(res_flags), 16'h2);
      check("bp_req_ready", 16'(req_ready), 16'h0);
      check("bp_cs_n", 16'(alu_cs_n), 16'h1);
      check("bp_alu_a", 16'(alu_a), 16'h40);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    #1;
    check("bp_release_ready", 16'(req_ready), 16'h1);
    tick();
    check("bp_xfer_done", 16'(res_valid), 16'h0);
    check("bp_cnt", 16'(op_cnt), 16'h7);
    tick();
    check("bp_no_dup", 16'(res_valid), 16'h0);
    check("bp_cnt_stable", 16'(op_cnt), 16'h7);

    // Reset during ISSUE discards the op; reset beats a simultaneous accept
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h05, 1'b0, 8'h06, 1'b1);
    tick();
    check("ri_first_accept", 16'(alu_cs_n), 16'h0);
    rst = 1'b1;
    tick();
    check("ri_acc", 16'(acc), 16'h0);
    check("ri_cnt", 16'(op_cnt), 16'h0);
    check("ri_valid", 16'(res_valid), 16'h0);
    check("ri_cs_n", 16'(alu_cs_n), 16'h1);
    check("ri_alu_a", 16'(alu_a), 16'h0);
    check("ri_idle_ready", 16'(req_ready), 16'h1);
    rst = 1'b0;
    req_valid = 1'b0;
    tick();
    check("ri_still_idle", 16'(res_valid), 16'h0);

    // 256 back-to-back ops wrap the completed-operation counter
    drive(1'b1, 8'h01, 1'b0, 8'h01, 1'b0);
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 255) req_valid = 1'b0;
      tick();
      if (i == 254) check("wrap_ff", 16'(op_cnt), 16'hFF);
    end
    check("wrap_00", 16'(op_cnt), 16'h00);
    check("wrap_res_f", 16'(res_f), 16'h02);
    check("wrap_flags", 16'(res_flags), 16'h1);
    tick();
    check("wrap_idle", 16'(res_valid), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
